// File: rtl/core_ctrl_pkg.sv
// Shared control types for the multicycle core: FSM states, opcodes, datapath select codes.
// Latency: none (types, constants and a pure decode function only).
// Backpressure: n/a.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    // Moore part of the control word; the mem_ready / branch-dependent bits are added later.
    typedef struct packed {
        logic        mem_req;
        logic        adr_src;
        logic        mem_write;
        logic        reg_write;
        logic        pc_write;
        logic        retire;
        result_src_t result_src;
        alu_src_a_t  alu_src_a;
        alu_src_b_t  alu_src_b;
        alu_op_t     alu_op;
    } ctrl_t;

    function automatic ctrl_t ctrl_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.result_src = RES_ALURESULT;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imm_src_decode.sv
// Immediate-format select decoded straight from the opcode field of IR.
// Latency: combinational.
// Backpressure: n/a.
module imm_src_decode
    import core_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    // Opcodes without an immediate fall back to the I format, which is harmless.
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/mem/writeback.
// Latency: lw 5, sw 4, R/I 4, branch 3, jal 4 cycles with mem_ready held high.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold one extra cycle per mem_ready=0 cycle.
module mc_ctrl_fsm
    import core_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_src,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retire_count,
    output logic             illegal
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl_q;
    logic   in_fetch;
    logic   in_branch;
    logic   in_memwrite;
    logic   branch_ok;

    imm_src_decode u_imm_src_decode (
        .op      (op),
        .imm_src (imm_src)
    );

    assign in_fetch    = (state == S_FETCH);
    assign in_branch   = (state == S_BRANCH);
    assign in_memwrite = (state == S_MEMWRITE);
    // Only beq (000) and bne (001) are supported; anything else traps.
    assign branch_ok   = (funct3[2:1] == 2'b00);

    // Next-state selection; unreachable encodings fall back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     state_next = S_FETCH;
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXEC_R;
                    OP_ITYPE:          state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXEC_R:   state_next = S_ALUWB;
            S_EXEC_I:   state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = branch_ok ? S_FETCH : S_TRAP;
            S_JAL:      state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_IDLE;
        endcase
    end

    // State, registered Moore control word, sticky trap flag and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ctrl_q       <= '0;
            illegal      <= 1'b0;
            retire_count <= '0;
        end else begin
            state  <= state_next;
            ctrl_q <= ctrl_decode(state_next);
            if (state_next == S_TRAP) begin
                illegal <= 1'b1;
            end
            if (instr_retired) begin
                retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Registered Moore fields go straight out; handshake and branch outcome are gated in here.
    assign mem_req       = ctrl_q.mem_req;
    assign adr_src       = ctrl_q.adr_src;
    assign mem_write     = ctrl_q.mem_write;
    assign reg_write     = ctrl_q.reg_write;
    assign result_src    = ctrl_q.result_src;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign ir_write      = in_fetch & mem_ready;
    assign pc_write      = ctrl_q.pc_write
                         | (in_fetch & mem_ready)
                         | (in_branch & branch_ok & (zero ^ funct3[0]));
    assign instr_retired = ctrl_q.retire
                         | (in_memwrite & mem_ready)
                         | (in_branch & branch_ok);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm built with a 4-bit retire counter.
// Latency: n/a.
// Backpressure: mem_ready stalls are driven per cycle from the stimulus tables.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic       instr_retired;
    logic [3:0] retire_count;
    logic       illegal;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_cnt = 4'd0;

    // Output order: mem_req adr_src mem_write ir_write pc_write reg_write result_src alu_src_a alu_src_b alu_op instr_retired
    logic [14:0] outs;
    assign outs = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
                   result_src, alu_src_a, alu_src_b, alu_op, instr_retired};

    localparam logic [14:0] E_IDLE     = 15'b0_0_0_0_0_0_00_00_00_00_0;
    localparam logic [14:0] E_FETCH_R  = 15'b1_0_0_1_1_0_10_00_10_00_0;
    localparam logic [14:0] E_FETCH_W  = 15'b1_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] E_DECODE   = 15'b0_0_0_0_0_0_00_01_01_00_0;
    localparam logic [14:0] E_MEMADR   = 15'b0_0_0_0_0_0_00_10_01_00_0;
    localparam logic [14:0] E_MEMREAD  = 15'b1_1_0_0_0_0_00_00_00_00_0;
    localparam logic [14:0] E_MEMWB    = 15'b0_0_0_0_0_1_01_00_00_00_1;
    localparam logic [14:0] E_MEMWR_R  = 15'b1_1_1_0_0_0_00_00_00_00_1;
    localparam logic [14:0] E_MEMWR_W  = 15'b1_1_1_0_0_0_00_00_00_00_0;
    localparam logic [14:0] E_EXEC_R   = 15'b0_0_0_0_0_0_00_10_00_10_0;
    localparam logic [14:0] E_EXEC_I   = 15'b0_0_0_0_0_0_00_10_01_10_0;
    localparam logic [14:0] E_ALUWB    = 15'b0_0_0_0_0_1_00_00_00_00_1;
    localparam logic [14:0] E_BR_T     = 15'b0_0_0_0_1_0_00_10_00_01_1;
    localparam logic [14:0] E_BR_NT    = 15'b0_0_0_0_0_0_00_10_00_01_1;
    localparam logic [14:0] E_BR_BAD   = 15'b0_0_0_0_0_0_00_10_00_01_0;
    localparam logic [14:0] E_JAL      = 15'b0_0_0_0_1_0_00_01_10_00_0;

    typedef struct packed {
        logic        rdy;
        logic        z;
        logic [14:0] e;
    } row_t;

    mc_ctrl_fsm #(.CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .funct3        (funct3),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .imm_src       (imm_src),
        .instr_retired (instr_retired),
        .retire_count  (retire_count),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; op = 7'b0100011; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
        #3;
        checks++; if (outs !== E_IDLE) begin errors++; $display("FAIL reset_outs got=%h want=%h", outs, E_IDLE); end
        checks++; if (retire_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", retire_count); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b want=0", illegal); end
        checks++; if (imm_src !== 2'b01) begin errors++; $display("FAIL imm_src_store got=%b want=01", imm_src); end
        op = 7'b1100011; #1;
        checks++; if (imm_src !== 2'b10) begin errors++; $display("FAIL imm_src_branch got=%b want=10", imm_src); end
        op = 7'b1101111; #1;
        checks++; if (imm_src !== 2'b11) begin errors++; $display("FAIL imm_src_jal got=%b want=11", imm_src); end
        op = 7'b0110011; #1;
        checks++; if (imm_src !== 2'b00) begin errors++; $display("FAIL imm_src_rtype got=%b want=00", imm_src); end
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        checks++; if (outs !== E_IDLE) begin errors++; $display("FAIL idle_outs got=%h want=%h", outs, E_IDLE); end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        row_t rows [4];
        op = 7'b0110011;
        rows = '{'{1'b1, 1'b0, E_FETCH_R}, '{1'b0, 1'b0, E_DECODE},
                 '{1'b0, 1'b0, E_EXEC_R},  '{1'b0, 1'b0, E_ALUWB}};
        for (int i = 0; i < 4; i++) begin
            mem_ready = rows[i].rdy; zero = rows[i].z; #1;
            checks++; if (outs !== rows[i].e) begin errors++; $display("FAIL rtype cyc%0d got=%h want=%h", i, outs, rows[i].e); end
            @(posedge clk); #1;
        end
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL rtype_count got=%0d want=%0d", retire_count, exp_cnt); end
    endtask

    task automatic test_itype();
        row_t rows [4];
        op = 7'b0010011;
        rows = '{'{1'b1, 1'b0, E_FETCH_R}, '{1'b1, 1'b0, E_DECODE},
                 '{1'b0, 1'b0, E_EXEC_I},  '{1'b0, 1'b0, E_ALUWB}};
        for (int i = 0; i < 4; i++) begin
            mem_ready = rows[i].rdy; zero = rows[i].z; #1;
            checks++; if (outs !== rows[i].e) begin errors++; $display("FAIL itype cyc%0d got=%h want=%h", i, outs, rows[i].e); end
            @(posedge clk); #1;
        end
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL itype_count got=%0d want=%0d", retire_count, exp_cnt); end
    endtask

    task automatic test_lw_stall();
        row_t rows [8];
        op = 7'b0000011;
        rows = '{'{1'b0, 1'b0, E_FETCH_W}, '{1'b0, 1'b0, E_FETCH_W}, '{1'b1, 1'b0, E_FETCH_R},
                 '{1'b0, 1'b0, E_DECODE},  '{1'b0, 1'b0, E_MEMADR},  '{1'b0, 1'b0, E_MEMREAD},
                 '{1'b1, 1'b0, E_MEMREAD}, '{1'b0, 1'b0, E_MEMWB}};
        for (int i = 0; i < 8; i++) begin
            mem_ready = rows[i].rdy; zero = rows[i].z; #1;
            checks++; if (outs !== rows[i].e) begin errors++; $display("FAIL lw cyc%0d got=%h want=%h", i, outs, rows[i].e); end
            @(posedge clk); #1;
        end
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL lw_count got=%0d want=%0d", retire_count, exp_cnt); end
    endtask

    task automatic test_sw();
        row_t rows [5];
        op = 7'b0100011;
        rows = '{'{1'b1, 1'b0, E_FETCH_R}, '{1'b1, 1'b0, E_DECODE}, '{1'b1, 1'b0, E_MEMADR},
                 '{1'b0, 1'b0, E_MEMWR_W}, '{1'b1, 1'b0, E_MEMWR_R}};
        for (int i = 0; i < 5; i++) begin
            mem_ready = rows[i].rdy; zero = rows[i].z; #1;
            checks++; if (outs !== rows[i].e) begin errors++; $display("FAIL sw cyc%0d got=%h want=%h", i, outs, rows[i].e); end
            @(posedge clk); #1;
        end
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL sw_count got=%0d want=%0d", retire_count, exp_cnt); end
    endtask

    // beq z=1 taken, beq z=0 not, bne z=1 not, bne z=0 taken.
    task automatic test_branch();
        logic [2:0]  f3_tbl [4];
        logic        z_tbl  [4];
        logic [14:0] br_tbl [4];
        row_t        rows   [3];
        f3_tbl = '{3'b000, 3'b000, 3'b001, 3'b001};
        z_tbl  = '{1'b1, 1'b0, 1'b1, 1'b0};
        br_tbl = '{E_BR_T, E_BR_NT, E_BR_NT, E_BR_T};
        op = 7'b1100011;
        for (int k = 0; k < 4; k++) begin
            funct3 = f3_tbl[k];
            rows = '{'{1'b1, 1'b0, E_FETCH_R}, '{1'b1, 1'b0, E_DECODE}, '{1'b0, z_tbl[k], br_tbl[k]}};
            for (int i = 0; i < 3; i++) begin
                mem_ready = rows[i].rdy; zero = rows[i].z; #1;
                checks++; if (outs !== rows[i].e) begin errors++; $display("FAIL branch%0d cyc%0d got=%h want=%h", k, i, outs, rows[i].e); end
                @(posedge clk); #1;
            end
            exp_cnt = exp_cnt + 4'd1;
            checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL branch%0d_count got=%0d want=%0d", k, retire_count, exp_cnt); end
        end
        funct3 = 3'b000; zero = 1'b0;
    endtask

    task automatic test_jal();
        row_t rows [4];
        op = 7'b1101111;
        rows = '{'{1'b1, 1'b0, E_FETCH_R}, '{1'b1, 1'b0, E_DECODE},
                 '{1'b0, 1'b0, E_JAL},     '{1'b0, 1'b0, E_ALUWB}};
        for (int i = 0; i < 4; i++) begin
            mem_ready = rows[i].rdy; zero = rows[i].z; #1;
            checks++; if (outs !== rows[i].e) begin errors++; $display("FAIL jal cyc%0d got=%h want=%h", i, outs, rows[i].e); end
            @(posedge clk); #1;
        end
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL jal_count got=%0d want=%0d", retire_count, exp_cnt); end
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 16 && exp_cnt != 4'd15; n++) begin
            test_rtype();
        end
        checks++; if (retire_count !== 4'd15) begin errors++; $display("FAIL wrap_pre got=%0d want=15", retire_count); end
        test_rtype();
        checks++; if (retire_count !== 4'd0) begin errors++; $display("FAIL wrap_post got=%0d want=0", retire_count); end
    endtask

    task automatic test_reset_mid_write();
        row_t rows [4];
        op = 7'b0100011;
        rows = '{'{1'b1, 1'b0, E_FETCH_R}, '{1'b1, 1'b0, E_DECODE},
                 '{1'b0, 1'b0, E_MEMADR},  '{1'b0, 1'b0, E_MEMWR_W}};
        for (int i = 0; i < 4; i++) begin
            mem_ready = rows[i].rdy; zero = rows[i].z; #1;
            checks++; if (outs !== rows[i].e) begin errors++; $display("FAIL midrst cyc%0d got=%h want=%h", i, outs, rows[i].e); end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        #1 rst_n = 1'b0; #1;
        checks++; if (mem_write !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL midrst_drop mem_write=%b mem_req=%b want=0", mem_write, mem_req); end
        checks++; if (outs !== E_IDLE) begin errors++; $display("FAIL midrst_outs got=%h want=%h", outs, E_IDLE); end
        checks++; if (retire_count !== 4'd0) begin errors++; $display("FAIL midrst_count got=%0d want=0", retire_count); end
        exp_cnt = 4'd0;
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b1; #1;
        checks++; if (outs !== E_IDLE) begin errors++; $display("FAIL midrst_idle got=%h want=%h", outs, E_IDLE); end
        @(posedge clk); #1;
        checks++; if (outs !== E_FETCH_R) begin errors++; $display("FAIL midrst_fetch got=%h want=%h", outs, E_FETCH_R); end
    endtask

    task automatic test_trap_opcode();
        row_t rows [2];
        op = 7'b1111111;
        rows = '{'{1'b1, 1'b0, E_FETCH_R}, '{1'b1, 1'b0, E_DECODE}};
        for (int i = 0; i < 2; i++) begin
            mem_ready = rows[i].rdy; zero = rows[i].z; #1;
            checks++; if (outs !== rows[i].e) begin errors++; $display("FAIL trap cyc%0d got=%h want=%h", i, outs, rows[i].e); end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 12; i++) begin
            mem_ready = 1'($urandom_range(1, 0)); zero = 1'($urandom_range(1, 0)); op = 7'b0110011; #1;
            checks++; if (outs !== E_IDLE || illegal !== 1'b1) begin errors++; $display("FAIL trap_hold cyc%0d outs=%h illegal=%b want outs=0 illegal=1", i, outs, illegal); end
            checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL trap_count cyc%0d got=%0d want=%0d", i, retire_count, exp_cnt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bad_branch();
        row_t rows [3];
        rst_n = 1'b0; #1;
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rerst_illegal got=%b want=0", illegal); end
        exp_cnt = 4'd0;
        @(posedge clk); #1;
        op = 7'b1100011; funct3 = 3'b011;
        rows = '{'{1'b1, 1'b0, E_FETCH_R}, '{1'b1, 1'b0, E_DECODE}, '{1'b1, 1'b0, E_BR_BAD}};
        for (int i = 0; i < 3; i++) begin
            mem_ready = rows[i].rdy; zero = rows[i].z; #1;
            checks++; if (outs !== rows[i].e) begin errors++; $display("FAIL badbr cyc%0d got=%h want=%h", i, outs, rows[i].e); end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (outs !== E_IDLE || illegal !== 1'b1 || retire_count !== 4'd0) begin errors++; $display("FAIL badbr_trap cyc%0d outs=%h illegal=%b count=%0d want 0/1/0", i, outs, illegal, retire_count); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch();
        test_sw();
        test_itype();
        test_jal();
        test_wrap();
        test_reset_mid_write();
        test_rtype();
        test_trap_opcode();
        test_bad_branch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared datapath (PC, IR, register file, ALU, ALUOut, unified memory port) through fetch/decode/execute/memory/writeback for lw, sw, R-type, I-type ALU, beq/bne and jal.
- Emits the 2-bit ALUOp class consumed by the existing ALU decoder, plus mux selects and write enables.
- Adds a ready handshake on the memory port and an illegal-opcode trap.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- adr_src  out  1  0 = PC, 1 = ALUOut
- mem_write  out  1  store enable
- ir_write  out  1  IR and OldPC load
- pc_write  out  1  PC load
- reg_write  out  1  register-file write
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 Imm, 10 const 4
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
- imm_src  out  2  00 I, 01 S, 10 B, 11 J (combinational from op)
- instr_retired  out  1  1-cycle pulse on instruction completion
- retire_count  out  CNT_W  retired instruction count
- illegal  out  1  sticky trap flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, retire_count=0, illegal=0.
  - In IDLE every output is 0 except imm_src, which decodes op.
  - IDLE→FETCH on the first clk edge after rst_n deasserts.
- Outputs are Moore (decoded from state) except the mem_ready gating and branch pc_write below. Unlisted outputs are 0.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Hold while mem_ready=0; →DECODE when 1.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
  - Next state by op: 0000011/0100011→MEMADR, 0110011→EXEC_R, 0010011→EXEC_I, 1100011→BRANCH, 1101111→JAL, others→TRAP.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; →MEMREAD if op[5]=0, else →MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1; hold until mem_ready; →MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_retired=1; →FETCH.
- MEMWRITE: mem_req=1, adr_src=1, mem_write=1 (held until accepted); on mem_ready: instr_retired=1, →FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10; →ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10; →ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_retired=1; →FETCH.
- BRANCH:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero XOR funct3[0] (beq taken on zero, bne taken on !zero).
  - funct3 other than 000/001 → TRAP instead, with pc_write=0.
  - Otherwise instr_retired=1; →FETCH.
- JAL:
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1.
  - Next cycle is ALUWB, which writes PC+4 to rd and pulses instr_retired. JAL itself does not pulse.
- TRAP: illegal=1, sticky until reset. All enables 0, mem_req=0. FSM stays in TRAP.
- Cycle counts with mem_ready always 1: lw 5, sw 4, R/I 4, branch 3, jal 4.
- Each mem_ready=0 cycle adds exactly 1 cycle.
- mem_ready is ignored outside FETCH/MEMREAD/MEMWRITE.
- retire_count increments on instr_retired and wraps from all-ones to 0.
- Reset mid-access: mem_req, mem_write and every write enable drop to 0 asynchronously in the same cycle rst_n falls; no partial writeback.
- State encoding: enum in the shared package; an unreachable encoding recovers to IDLE.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - the state enum;
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL;
  - enums for result_src, alu_src_a, alu_src_b, alu_op, imm_src.
- Natural sub-module: imm_src_decode (combinational op→imm_src).
- Next-state logic, output decode and counter stay in mc_ctrl_fsm.

Test Plan:
- Reset, then op=0110011, mem_ready=1 → IDLE, FETCH, DECODE, EXEC_R (alu_op=10), ALUWB (reg_write=1, instr_retired=1); retire_count=1.
- lw (op=0000011) with mem_ready low 2 cycles in FETCH and 1 in MEMREAD → total 8 cycles; ir_write and pc_write only on the ready cycle of FETCH; reg_write with result_src=01.
- beq (funct3=000): zero=1 → pc_write=1 in BRANCH; zero=0 → pc_write=0. bne (funct3=001) inverts this; each retires in 3 cycles.
- jal (op=1101111) → JAL with pc_write=1 and alu_src_a=01, alu_src_b=10; then ALUWB with reg_write=1, result_src=00.
- op=1111111 → TRAP after DECODE; illegal=1 and held; all enables 0 for 10+ cycles; retire_count unchanged.
- rst_n dropped during MEMWRITE with mem_ready=0 → mem_write and mem_req 0 immediately; retire_count=0; after release IDLE then FETCH.
- Force retire_count to all-ones (CNT_W=4 build) and retire one instruction → retire_count=0.
